det3_engine: RTL

Sequential, parametrised 3×3 signed determinant engine that succeeds the fixed 8-bit determinant datapath/controller pair. It fetches nine row-major elements from a combinational ROM port, then evaluates the cofactor expansion along row 0 on one shared signed multiplier with a single accumulator. It sits between the top-level controller (start/done handshake) and the coefficient ROM.

---
 rtl/det_pkg.sv | 36 +++
 rtl/det3_engine_if.sv | 29 ++
 rtl/det_mac.sv | 39 +++
 rtl/det3_engine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared types and helpers for the 3x3 determinant engine.
package det_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, CALC, DONE} state_t;
    typedef enum logic [1:0] {S0, S1, S2} step_t;

    // Multiplier/accumulator operation: *_M target the minor register, *_A the accumulator.
    typedef enum logic [2:0] {
        MAC_NOP,
        MAC_LD_M,
        MAC_SUB_M,
        MAC_LD_A,
        MAC_ADD_A,
        MAC_SUB_A
    } mac_op_t;

    localparam int N3 = 9;
    localparam int N2 = 4;

    typedef struct packed {
        logic [1:0] p;
        logic [1:0] q;
    } pair_t;

    // The two columns other than j, in ascending order.
    function automatic pair_t col_pair(input logic [1:0] j);
        pair_t r;
        case (j)
            2'd0:    r = '{p: 2'd1, q: 2'd2};
            2'd1:    r = '{p: 2'd0, q: 2'd2};
            default: r = '{p: 2'd0, q: 2'd1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/det3_engine_if.sv
// Controller/ROM-facing bus of det3_engine; the mode signal exists only with DET2X2_MODE_EN.
interface det3_engine_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    localparam int RW = 3 * DW + 3;

    logic                 start;
    logic [AW-1:0]        start_address;
    logic                 busy;
    logic                 done;
    logic signed [RW-1:0] result;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] mem_data;
`ifdef DET2X2_MODE_EN
    logic                 mode;

    modport master (output start, start_address, mem_data, mode,
                    input  busy, done, result, mem_addr);
    modport slave  (input  start, start_address, mem_data, mode,
                    output busy, done, result, mem_addr);
`else
    modport master (output start, start_address, mem_data,
                    input  busy, done, result, mem_addr);
    modport slave  (input  start, start_address, mem_data,
                    output busy, done, result, mem_addr);
`endif

endinterface

// File: rtl/det_mac.sv
// Shared signed multiplier feeding a minor register and the determinant accumulator.
module det_mac
    import det_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 3 * DW + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  mac_op_t               op,
    input  logic signed [DW-1:0]  op_a,
    input  logic signed [2*DW:0]  op_b,
    output logic signed [2*DW:0]  minor,
    output logic signed [RW-1:0]  acc
);
    localparam int PW = 3 * DW + 1;

    logic signed [PW-1:0] prod;

    // Size casts of signed operands sign-extend, so the product is exact in PW bits.
    assign prod = PW'(op_a) * PW'(op_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            minor <= '0;
            acc   <= '0;
        end else begin
            case (op)
                MAC_LD_M:  minor <= prod[2*DW:0];
                MAC_SUB_M: minor <= minor - prod[2*DW:0];
                MAC_LD_A:  acc   <= RW'(prod);
                MAC_ADD_A: acc   <= acc + RW'(prod);
                MAC_SUB_A: acc   <= acc - RW'(prod);
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/det3_engine.sv
// Sequential 3x3 signed determinant engine: ROM fetch, then cofactor expansion along row 0.
// Optional 2x2 mode is compiled in with DET2X2_MODE_EN.
module det3_engine
    import det_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input logic          clk,
    input logic          rst,
    det3_engine_if.slave bus
);
    localparam int RW = 3 * DW + 3;

    state_t               state, state_nx;
    step_t                sub;
    logic [1:0]           col;
    logic [3:0]           idx;
    logic [AW-1:0]        base;
    logic [AW-1:0]        mem_addr_q;
    logic                 done_q;
    logic signed [RW-1:0] result_q;
    logic signed [DW-1:0] e [N3];

    mac_op_t              mac_op;
    logic signed [DW-1:0] op_a;
    logic signed [2*DW:0] op_b;
    logic signed [2*DW:0] minor;
    logic signed [RW-1:0] acc;
    logic                 busy;
    logic                 last_elem, last_step;
    pair_t                pair;
    logic [3:0]           ia, ib;

`ifdef DET2X2_MODE_EN
    logic mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          mode_q <= 1'b0;
        else if (state == IDLE && bus.start) mode_q <= bus.mode;
    end

    assign last_elem = idx == (mode_q ? 4'(N2 - 1) : 4'(N3 - 1));
    assign last_step = mode_q ? (sub == S1) : (col == 2'd2 && sub == S2);
`else
    assign last_elem = idx == 4'(N3 - 1);
    assign last_step = col == 2'd2 && sub == S2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = FETCH;
            FETCH:   if (last_elem) state_nx = CALC;
            CALC:    if (last_step) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        busy   = 1'b0;
        mac_op = MAC_NOP;
        op_a   = '0;
        op_b   = '0;
        pair   = col_pair(col);
        ia     = '0;
        ib     = '0;
        case (state)
            FETCH: busy = 1'b1;
            CALC: begin
                busy = 1'b1;
`ifdef DET2X2_MODE_EN
                if (mode_q) begin
                    op_a   = (sub == S0) ? e[0] : e[1];
                    op_b   = (2*DW+1)'((sub == S0) ? e[3] : e[2]);
                    mac_op = (sub == S0) ? MAC_LD_A : MAC_SUB_A;
                end else
`endif
                begin
                    case (sub)
                        S0: begin
                            ia     = 4'd3 + {2'b00, pair.p};
                            ib     = 4'd6 + {2'b00, pair.q};
                            mac_op = MAC_LD_M;
                        end
                        S1: begin
                            ia     = 4'd3 + {2'b00, pair.q};
                            ib     = 4'd6 + {2'b00, pair.p};
                            mac_op = MAC_SUB_M;
                        end
                        default: begin
                            ia     = {2'b00, col};
                            mac_op = (col == 2'd0) ? MAC_LD_A :
                                     (col == 2'd1) ? MAC_SUB_A : MAC_ADD_A;
                        end
                    endcase
                    op_a = e[ia];
                    op_b = (sub == S2) ? minor : (2*DW+1)'(e[ib]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            col        <= '0;
            sub        <= S0;
            base       <= '0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            // NOTE: the element registers have a defined reset value, so the array is cleared here.
            for (int k = 0; k < N3; k++) e[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    idx        <= '0;
                    col        <= '0;
                    sub        <= S0;
                    base       <= bus.start_address;
                    mem_addr_q <= bus.start_address;
                end
                FETCH: begin
                    e[idx]     <= bus.mem_data;
                    idx        <= idx + 4'd1;
                    mem_addr_q <= base + AW'(idx) + AW'(1);
                end
                CALC: begin
                    case (sub)
                        S0: sub <= S1;
                        S1: sub <= S2;
                        default: begin
                            sub <= S0;
                            col <= col + 2'd1;
                        end
                    endcase
                end
                default: begin
                    result_q <= acc;
                    done_q   <= 1'b1;
                end
            endcase
        end
    end

    det_mac #(.DW(DW), .RW(RW)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .op    (mac_op),
        .op_a  (op_a),
        .op_b  (op_b),
        .minor (minor),
        .acc   (acc)
    );

    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.mem_addr = mem_addr_q;

endmodule
